// File: rtl/correlate.sv
// correlate: census Hamming-distance disparity search.
// Three register stages: XOR of the census pair, popcount, then a running
// argmin over NUM_DISP consecutive valid candidates of one left pixel.
// Valid/ready contract: bitvec_val qualifies left/right for one cycle with no
// backpressure. disparity_val is a one-cycle pulse; the result outputs hold
// their values between pulses.
module correlate #(
    parameter int NUM_DISP = 64,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] left_bitvec,
    input  logic [71:0] right_bitvec,
    input  logic        bitvec_val,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        disparity_val,
    output logic [5:0]  disparity
);

    localparam logic [5:0] LAST_CAND = 6'(NUM_DISP - 1);
    localparam logic [9:0] X_LAST    = 10'(IMG_W - 1);
    localparam logic [8:0] Y_LAST    = 9'(IMG_H - 1);
    localparam logic [6:0] COST_INIT = 7'd127;

    // Number of set bits in a 72-bit difference vector (0..72).
    function automatic logic [6:0] f_popcount(input logic [71:0] v);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < 72; i++) begin
            s = s + {6'd0, v[i]};
        end
        return s;
    endfunction

    // Stage 1 registers
    logic        r_s1_val;
    logic [71:0] r_s1_diff;
    // Stage 2 registers
    logic        r_s2_val;
    logic [6:0]  r_s2_cost;
    // Stage 3 search state
    logic [5:0]  r_cand;
    logic [6:0]  r_best_cost;
    logic [5:0]  r_best_disp;
    logic [9:0]  r_px;
    logic [8:0]  r_py;
    // Result registers
    logic        r_dval;
    logic [5:0]  r_disp;
    logic [9:0]  r_out_x;
    logic [8:0]  r_out_y;

    // Search combinational terms
    logic        w_run_last;
    logic        w_take;
    logic [6:0]  w_best_cost_nx;
    logic [5:0]  w_best_disp_nx;
    logic        w_pix_done;

    // Stage 1: capture the XOR only on valid cycles so X/Z on idle cycles never reaches state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_val  <= 1'b0;
            r_s1_diff <= '0;
        end else begin
            r_s1_val <= bitvec_val;
            if (bitvec_val) begin
                r_s1_diff <= left_bitvec ^ right_bitvec;
            end
        end
    end

    // Stage 2: reduce the difference vector to a Hamming cost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_val  <= 1'b0;
            r_s2_cost <= '0;
        end else begin
            r_s2_val <= r_s1_val;
            if (r_s1_val) begin
                r_s2_cost <= f_popcount(r_s1_diff);
            end
        end
    end

    // Candidate 0 always seeds the search; later candidates replace only on a
    // strictly lower cost, so ties keep the lower disparity.
    always_comb begin
        w_run_last     = (r_cand == LAST_CAND);
        w_take         = (r_cand == 6'd0) || (r_s2_cost < r_best_cost);
        w_best_cost_nx = w_take ? r_s2_cost : r_best_cost;
        w_best_disp_nx = w_take ? r_cand : r_best_disp;
        w_pix_done     = r_s2_val && w_run_last;
    end

    // Stage 3: running argmin over the candidates of one pixel; gaps simply stall it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand      <= '0;
            r_best_cost <= COST_INIT;
            r_best_disp <= '0;
        end else if (r_s2_val) begin
            r_best_cost <= w_best_cost_nx;
            r_best_disp <= w_best_disp_nx;
            if (w_run_last) begin
                r_cand <= '0;
            end else begin
                r_cand <= r_cand + 6'd1;
            end
        end
    end

    // Pixel position counter: advances once per completed run, raster order with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_px <= '0;
            r_py <= '0;
        end else if (w_pix_done) begin
            if (r_px == X_LAST) begin
                r_px <= '0;
                if (r_py == Y_LAST) begin
                    r_py <= '0;
                end else begin
                    r_py <= r_py + 9'd1;
                end
            end else begin
                r_px <= r_px + 10'd1;
            end
        end
    end

    // Result registers: load on run completion and pulse valid; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dval  <= 1'b0;
            r_disp  <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
        end else begin
            r_dval <= w_pix_done;
            if (w_pix_done) begin
                r_disp  <= w_best_disp_nx;
                r_out_x <= r_px;
                r_out_y <= r_py;
            end
        end
    end

    assign disparity_val = r_dval;
    assign disparity     = r_disp;
    assign pixel_x       = r_out_x;
    assign pixel_y       = r_out_y;

endmodule

// File: tb/tb_correlate.sv
// Bench for correlate: directed table of full pixel runs, hand-written corner
// sequences (ramp/partial run, reset mid-run) and randomized runs with gaps,
// all checked against a cost-list/argmin reference model.
module tb_correlate;

  localparam int NUM_DISP = 64;
  localparam int IMG_W    = 3;
  localparam int IMG_H    = 2;
  localparam int EW       = 57;  // {edge[32], y[9], x[10], disp[6]}

  logic        clk;
  logic        reset;
  logic [71:0] left_bitvec;
  logic [71:0] right_bitvec;
  logic        bitvec_val;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        disparity_val;
  logic [5:0]  disparity;

  correlate #(.NUM_DISP(NUM_DISP), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk           (clk),
    .reset         (reset),
    .left_bitvec   (left_bitvec),
    .right_bitvec  (right_bitvec),
    .bitvec_val    (bitvec_val),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .disparity_val (disparity_val),
    .disparity     (disparity)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [EW-1:0] exp_q[$];
  int m_costs[$];
  int m_x = 0;
  int m_y = 0;
  int hold_disp = 0;
  int hold_x = 0;
  int hold_y = 0;
  int obs_cnt = 0;
  int obs_disp = 0;
  int obs_x = 0;
  int obs_y = 0;
  int obs_hist[$];

  typedef struct {
    int kind;      // 0 desc 72-k, 1 tie at a/b, 2 single min at a, 3 ascending, 4 flat
    int a;
    int b;
    bit gaps;
    int exp_disp;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [71:0] ones_mask(input int c);
    logic [71:0] m;
    m = '0;
    for (int i = 0; i < c; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [71:0] rand72();
    return {8'($urandom()), $urandom(), $urandom()};
  endfunction

  function automatic int cost_of(input vec_t v, input int k);
    case (v.kind)
      0: return 72 - k;
      1: return (k == v.a || k == v.b) ? 5 : 20;
      2: return (k == v.a) ? 3 : 30;
      3: return k + 1;
      default: return 9;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: collect costs; on the NUM_DISP-th, first minimum wins.
  task automatic model_push(input logic [71:0] l, input logic [71:0] r, input int s_edge);
    int best;
    m_costs.push_back($countones(l ^ r));
    if (m_costs.size() == NUM_DISP) begin
      best = 0;
      for (int i = 1; i < NUM_DISP; i++) if (m_costs[i] < m_costs[best]) best = i;
      exp_q.push_back({32'(s_edge + 2), 9'(m_y), 10'(m_x), 6'(best)});
      m_x++;
      if (m_x == IMG_W) begin
        m_x = 0;
        m_y++;
        if (m_y == IMG_H) m_y = 0;
      end
      m_costs.delete();
    end
  endtask

  // Sampled #1 after each rising edge.
  task automatic monitor();
    logic [EW-1:0] e;
    if (disparity_val) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got disp=%0d x=%0d y=%0d, expected no pulse",
                 disparity, pixel_x, pixel_y);
      end else begin
        e = exp_q.pop_front();
        if (disparity != e[5:0] || pixel_x != e[15:6] || pixel_y != e[24:16] ||
            edge_n != int'(e[56:25])) begin
          errors++;
          $display("FAIL pulse: got disp=%0d x=%0d y=%0d edge=%0d, expected disp=%0d x=%0d y=%0d edge=%0d",
                   disparity, pixel_x, pixel_y, edge_n, e[5:0], e[15:6], e[24:16], e[56:25]);
        end
        hold_disp = int'(e[5:0]);
        hold_x    = int'(e[15:6]);
        hold_y    = int'(e[24:16]);
      end
      obs_cnt++;
      obs_disp = int'(disparity);
      obs_x    = int'(pixel_x);
      obs_y    = int'(pixel_y);
      obs_hist.push_back(int'(disparity));
    end else begin
      checks++;
      if (int'(disparity) != hold_disp || int'(pixel_x) != hold_x || int'(pixel_y) != hold_y) begin
        errors++;
        $display("FAIL hold: got disp=%0d x=%0d y=%0d, expected disp=%0d x=%0d y=%0d",
                 disparity, pixel_x, pixel_y, hold_disp, hold_x, hold_y);
      end
      if (exp_q.size() > 0 && int'(exp_q[0][56:25]) <= edge_n) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: got no pulse at edge %0d, expected disp=%0d", edge_n, e[5:0]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [71:0] l, input logic [71:0] r);
    bitvec_val   = v;
    left_bitvec  = l;
    right_bitvec = r;
    if (v) model_push(l, r, edge_n + 1);
    @(posedge clk);
    edge_n++;
    #1;
    monitor();
  endtask

  task automatic drive_gap();
    drive(1'b0, 72'bz, 72'bx);
  endtask

  task automatic drive_cost(input int c);
    logic [71:0] l;
    l = rand72();
    drive(1'b1, l, l ^ ones_mask(c));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bitvec_val = 1'b0;
    @(posedge clk);
    edge_n++;
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_costs.delete();
    m_x = 0; m_y = 0;
    hold_disp = 0; hold_x = 0; hold_y = 0;
    monitor();
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n;
    n = 0;
    while (obs_cnt < target && n < budget) begin
      drive_gap();
      n++;
    end
    if (obs_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pulses, expected %0d", obs_cnt, target);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int base;
    logic [71:0] r;
    logic [71:0] all1;

    tbl[0] = '{2, 7, 0, 1'b0, 7};
    tbl[1] = '{2, 0, 0, 1'b0, 0};
    tbl[2] = '{2, 63, 0, 1'b0, 63};
    tbl[3] = '{0, 0, 0, 1'b0, 63};
    tbl[4] = '{1, 10, 40, 1'b0, 10};
    tbl[5] = '{0, 0, 0, 1'b1, 63};
    tbl[6] = '{3, 0, 0, 1'b0, 0};
    tbl[7] = '{4, 0, 0, 1'b1, 0};

    reset = 1'b0;
    bitvec_val = 1'b0;
    left_bitvec = '0;
    right_bitvec = '0;
    @(posedge clk);
    edge_n++;
    #1;
    do_reset();
    do_reset();

    // Ramp: cost k for k=1..72; only the first 64 complete a pixel.
    all1 = '1;
    for (int k = 1; k <= 72; k++) begin
      r = ~(all1 >> k);
      drive(1'b1, 72'd0, r);
    end
    wait_pulses(1, 10);
    for (int i = 0; i < 12; i++) drive_gap();
    chk("ramp_pulses", obs_cnt, 1);
    chk("ramp_disp", obs_disp, 0);
    chk("ramp_x", obs_x, 0);
    chk("ramp_y", obs_y, 0);

    // Reset mid-run: 30 more candidates, reset, then a clean run with min at 12.
    for (int k = 0; k < 30; k++) drive_cost($urandom_range(0, 72));
    do_reset();
    base = obs_cnt;
    for (int k = 0; k < NUM_DISP; k++) drive_cost((k == 12) ? 2 : 40);
    wait_pulses(base + 1, 10);
    for (int i = 0; i < 5; i++) drive_gap();
    chk("rst_pulses", obs_cnt, base + 1);
    chk("rst_disp", obs_disp, 12);
    chk("rst_x", obs_x, 0);
    chk("rst_y", obs_y, 0);

    // Table vectors, back-to-back pixels.
    base = obs_cnt;
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < NUM_DISP; k++) begin
        if (tbl[v].gaps && $urandom_range(0, 2) == 0) begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) drive_gap();
        end
        drive_cost(cost_of(tbl[v], k));
      end
    end
    wait_pulses(base + 8, 20);
    for (int v = 0; v < 8; v++) begin
      if (obs_hist.size() > base + v) chk($sformatf("tbl%0d_disp", v), obs_hist[base + v], tbl[v].exp_disp);
    end

    // Randomized runs with random gaps.
    base = obs_cnt;
    for (int p = 0; p < 12; p++) begin
      for (int k = 0; k < NUM_DISP; k++) begin
        if ($urandom_range(0, 3) == 0) drive_gap();
        drive_cost($urandom_range(0, 72));
      end
    end
    wait_pulses(base + 12, 20);
    for (int i = 0; i < 5; i++) drive_gap();
    chk("rand_pulses", obs_cnt, base + 12);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/correlate.md
# correlate

Stereo disparity search stage of the stereo-camera pipeline. Consumes a stream of 72-bit census-transform bit-vector pairs (left reference pixel vs. right candidate pixel), computes the Hamming distance of each pair, and, over a run of NUM_DISP consecutive valid candidates belonging to one left pixel, reports the candidate index with the smallest distance as that pixel's disparity. It sits between the census-transform/line-buffer stage and the depth-map writer.

## Interface
- NUM_DISP, 64: candidates per left pixel; legal range 2..64. Candidate index = disparity.
- IMG_W, 640: pixels per row, for pixel_x wrap.
- IMG_H, 480: rows per frame, for pixel_y wrap.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset. Clock clk.
- left_bitvec  in  72  census vector of the left (reference) pixel. Must be held for all candidates of one pixel, but is sampled with every valid pair.
- right_bitvec  in  72  census vector of the right candidate at the current disparity.
- bitvec_val  in  1  pair valid this cycle. No backpressure.
- pixel_x  out  10  column of the pixel whose result is presented.
- pixel_y  out  9  row of the pixel whose result is presented.
- disparity_val  out  1  one-cycle pulse: disparity/pixel_x/pixel_y hold a new result.
- disparity  out  6  argmin candidate index, 0..NUM_DISP-1.

## Operation
- Stage 1 (register): on a valid cycle, store diff = left_bitvec XOR right_bitvec and valid flag. Invalid cycles store valid=0. X/Z inputs while bitvec_val=0 must not affect state.
- Stage 2 (register): cost = popcount(diff), 7 bits, range 0..72; valid forwarded.
- Stage 3 (search): candidate counter cand (6 bits) advances only on valid stage-2 entries.
  - cand==0: best_cost <= cost, best_disp <= 0.
  - otherwise: if cost < best_cost (strict), best_cost <= cost, best_disp <= cand. Ties keep the lower disparity.
  - cand==NUM_DISP-1: final argmin uses the current cost combinationally. Register disparity and the current pixel_x/pixel_y to outputs, pulse disparity_val. cand returns to 0. Pixel counter advances: x+1, wrap at IMG_W-1 to 0 with y+1; y wraps at IMG_H-1 to 0.
- Gaps (bitvec_val low) between candidates are allowed anywhere. They stall the search without losing state.
- A partial run (fewer than NUM_DISP candidates) produces no output until it completes.

## Timing
- Reset values: disparity_val=0, disparity=0, pixel_x=0, pixel_y=0. Pipeline valids=0, cand=0, best_cost=127, pixel counters=0.
- Reset has priority over every other event. Reset mid-run discards the partial run and in-flight pipeline entries. The next valid pair after reset is candidate 0 of pixel (0,0).
- Latency: the edge that samples the last (NUM_DISP-th) valid pair is edge E. disparity_val is high in the cycle following edge E+2 (three register stages).
- disparity_val is high for exactly one cycle per completed pixel. Between pulses, disparity/pixel_x/pixel_y hold their last values.
- Throughput: one candidate per cycle. Back-to-back pixels are supported with no idle cycle. A new run's cand==0 may enter stage 3 on the cycle after the previous run's final candidate.

## Test plan
- Ramp: left=0, right with k ones for k=1..72 over consecutive valid cycles (shift-in of 1s from MSB). The first 64 give costs 1..64, so one pulse reports disparity=0 at pixel (0,0). The last 8 pairs are a partial run: no second pulse, even after right/left go Z with bitvec_val=0.
- Descending: 64 valid pairs with cost 72-k for k=0..63 -> disparity=63. The pulse lands exactly 3 cycles after the last pair is presented.
- Tie: costs 5 at candidates 10 and 40, all others 20 -> disparity=10.
- Gaps: the same 64 pairs as the descending test, with random bitvec_val=0 cycles inserted -> identical result. The pulse lands 3 cycles after the last valid pair.
- Back-to-back: 3 pixels × 64 pairs with minima at 7, 0, 63 -> three pulses, disparity 7/0/63 at pixel_x 0/1/2, pixel_y 0. With IMG_W=2, the third pulse shows x=0, y=1.
- Reset mid-run: 30 candidates, then a reset pulse, then 64 candidates with min at 12 -> single pulse, disparity=12, pixel (0,0).
